// File: rtl/noc_xbar_pkg.sv
// ============================================================================
// Module   : noc_xbar_pkg
// Brief    : Shared constants, port-index enum and select-width helper for
//            the registered NoC crossbar.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_xbar_pkg;

    localparam int NOC_FLIT_W = 32;
    localparam int NOC_PORTS  = 5;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } noc_port_e;

    // Ceiling log2, usable in parameter defaults.
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        for (int p = 1; p < n; p = p * 2) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_xbar_out_stage.sv
// ============================================================================
// Module   : noc_xbar_out_stage
// Brief    : One crossbar output: single-flit register with valid/ready
//            handshake and optional saturating flit counter
//            (NOC_XBAR_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_xbar_out_stage
    import noc_xbar_pkg::*;
#(
    parameter int WIDTH = NOC_FLIT_W
`ifdef NOC_XBAR_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             out_ready,
    output logic             can_load,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
`ifdef NOC_XBAR_STATS_EN
    , output logic [CNT_W-1:0] flit_cnt
`endif
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Empty or draining this cycle: a new flit may be written in.
    assign can_load  = !r_valid || out_ready;
    assign out_data  = r_data;
    assign out_valid = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= din;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef NOC_XBAR_STATS_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign flit_cnt = r_cnt;
`endif

endmodule

`default_nettype wire

// File: rtl/noc_xbar_reg.sv
// ============================================================================
// Module   : noc_xbar_reg
// Brief    : N_IN x N_OUT registered crossbar with per-output source select,
//            lowest-index-wins conflict resolution and sticky select error.
//            Define NOC_XBAR_STATS_EN to add per-output flit counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_xbar_reg
    import noc_xbar_pkg::*;
#(
    parameter int WIDTH = NOC_FLIT_W,
    parameter int N_IN  = NOC_PORTS,
    parameter int N_OUT = NOC_PORTS,
    parameter int SEL_W = sel_width(N_IN)
`ifdef NOC_XBAR_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH*N_IN-1:0]  in_data,
    input  logic [N_IN-1:0]        in_valid,
    output logic [N_IN-1:0]        in_ready,
    input  logic [SEL_W*N_OUT-1:0] sel,
    input  logic [N_OUT-1:0]       sel_en,
    output logic [WIDTH*N_OUT-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   conflict_err
`ifdef NOC_XBAR_STATS_EN
    , output logic [CNT_W*N_OUT-1:0] flit_cnt
`endif
);

    logic [SEL_W-1:0] w_sel [N_OUT];
    logic [WIDTH-1:0] w_mux [N_OUT];
    logic [N_OUT-1:0] w_in_rng;
    logic [N_OUT-1:0] w_cand;
    logic [N_OUT-1:0] w_win;
    logic [N_OUT-1:0] w_can_load;
    logic [N_OUT-1:0] w_xfer;
    logic             w_dup;
    logic             w_oor;
    logic             r_conflict_err;

    // Per-output source decode: range check, valid lookup and data mux.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            w_sel[k]    = sel[k*SEL_W +: SEL_W];
            w_in_rng[k] = 32'(w_sel[k]) < N_IN;
            w_cand[k]   = 1'b0;
            w_mux[k]    = '0;
            for (int i = 0; i < N_IN; i++) begin
                if (32'(w_sel[k]) == i) begin
                    w_cand[k] = sel_en[k] && in_valid[i];
                    w_mux[k]  = in_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Any lower-index candidate on the same source beats output k.
    always_comb begin
        w_win = '1;
        w_dup = 1'b0;
        w_oor = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (sel_en[k] && !w_in_rng[k]) begin
                w_oor = 1'b1;
            end
            for (int j = 0; j < k; j++) begin
                if (w_sel[j] == w_sel[k]) begin
                    if (w_cand[j] && w_cand[k]) begin
                        w_win[k] = 1'b0;
                    end
                    if (sel_en[j] && sel_en[k] && w_in_rng[k]) begin
                        w_dup = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_xfer   = w_cand & w_win & w_can_load;
        in_ready = '0;
        for (int k = 0; k < N_OUT; k++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (w_xfer[k] && (32'(w_sel[k]) == i)) begin
                    in_ready[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_err <= 1'b0;
        end else if (w_dup || w_oor) begin
            r_conflict_err <= 1'b1;
        end
    end

    assign conflict_err = r_conflict_err;

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        noc_xbar_out_stage #(
            .WIDTH (WIDTH)
`ifdef NOC_XBAR_STATS_EN
            , .CNT_W (CNT_W)
`endif
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (w_xfer[k]),
            .din       (w_mux[k]),
            .out_ready (out_ready[k]),
            .can_load  (w_can_load[k]),
            .out_data  (out_data[k*WIDTH +: WIDTH]),
            .out_valid (out_valid[k])
`ifdef NOC_XBAR_STATS_EN
            , .flit_cnt (flit_cnt[k*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_noc_xbar_reg.sv
// ============================================================================
// Module   : tb_noc_xbar_reg
// Brief    : Self-checking bench for noc_xbar_reg with per-output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_noc_xbar_reg;

    localparam int WIDTH = 32;
    localparam int N_IN  = 5;
    localparam int N_OUT = 5;
    localparam int SEL_W = 3;
`ifdef NOC_XBAR_STATS_EN
    localparam int CNT_W = 4;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [WIDTH*N_IN-1:0]  in_data;
    logic [N_IN-1:0]        in_valid;
    logic [N_IN-1:0]        in_ready;
    logic [SEL_W*N_OUT-1:0] sel;
    logic [N_OUT-1:0]       sel_en;
    logic [WIDTH*N_OUT-1:0] out_data;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic                   conflict_err;
`ifdef NOC_XBAR_STATS_EN
    logic [CNT_W*N_OUT-1:0] flit_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q [N_OUT][$];
    logic [WIDTH-1:0] mon_exp;

    always #5 clk = ~clk;

    noc_xbar_reg #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
`ifdef NOC_XBAR_STATS_EN
        , .CNT_W (CNT_W)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sel          (sel),
        .sel_en       (sel_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .conflict_err (conflict_err)
`ifdef NOC_XBAR_STATS_EN
        , .flit_cnt   (flit_cnt)
`endif
    );

    // Every flit leaving an output must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    total++;
                    if (exp_q[k].size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected out%0d got=%h required=none", k, out_data[k*WIDTH +: WIDTH]);
                    end else begin
                        mon_exp = exp_q[k].pop_front();
                        if (out_data[k*WIDTH +: WIDTH] !== mon_exp) begin
                            bad++;
                            $display("FAIL sb_data out%0d got=%h required=%h", k, out_data[k*WIDTH +: WIDTH], mon_exp);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] od(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    task automatic idle();
        sel_en   = '0;
        in_valid = '0;
    endtask

    task automatic set_sel(input int k, input int v);
        sel[k*SEL_W +: SEL_W] = SEL_W'(v);
    endtask

    task automatic set_in(input int i, input logic [WIDTH-1:0] d);
        in_data[i*WIDTH +: WIDTH] = d;
        in_valid[i] = 1'b1;
    endtask

    task automatic apply_reset();
        idle();
        #2 rst_n = 1'b0;
        for (int k = 0; k < N_OUT; k++) exp_q[k].delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 5'b0) begin bad++; $display("FAIL reset_valid got=%b required=%b", out_valid, 5'b0); end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h required=0", out_data); end
        total++;
        if (conflict_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b required=0", conflict_err); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 5'b0) begin bad++; $display("FAIL reset_in_ready got=%b required=0", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_permutation();
        out_ready = '1;
        for (int k = 0; k < N_OUT; k++) set_sel(k, N_IN - 1 - k);
        sel_en = '1;
        for (int i = 0; i < N_IN; i++) set_in(i, 32'hA0 + 32'(i));
        @(negedge clk);
        total++;
        if (in_ready !== 5'h1F) begin bad++; $display("FAIL perm_in_ready got=%b required=%b", in_ready, 5'h1F); end
        for (int k = 0; k < N_OUT; k++) exp_q[k].push_back(32'hA0 + 32'(N_IN - 1 - k));
        @(posedge clk); #1;
        idle();
        total++;
        if (out_valid !== 5'h1F) begin bad++; $display("FAIL perm_valid got=%b required=%b", out_valid, 5'h1F); end
        for (int k = 0; k < N_OUT; k++) begin
            total++;
            if (od(k) !== 32'hA0 + 32'(N_IN - 1 - k))
                begin bad++; $display("FAIL perm_data out%0d got=%h required=%h", k, od(k), 32'hA0 + 32'(N_IN - 1 - k)); end
        end
        total++;
        if (conflict_err !== 1'b0) begin bad++; $display("FAIL perm_err got=%b required=0", conflict_err); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 5'b0) begin bad++; $display("FAIL perm_pop_valid got=%b required=0", out_valid); end
        total++;
        if (od(0) !== 32'hA4) begin bad++; $display("FAIL perm_hold_data got=%h required=%h", od(0), 32'hA4); end
    endtask

    task automatic test_backpressure();
        out_ready = '1;
        set_sel(2, 0); sel_en[2] = 1'b1; set_in(0, 32'h1234);
        @(negedge clk);
        total++;
        if (in_ready !== 5'b00001) begin bad++; $display("FAIL bp_load_ready got=%b required=%b", in_ready, 5'b00001); end
        exp_q[2].push_back(32'h1234);
        @(posedge clk); #1;
        idle();
        out_ready[2] = 1'b0;
        set_sel(2, 1); sel_en[2] = 1'b1; set_in(1, 32'hBEEF);
        repeat (3) begin
            @(negedge clk);
            total++;
            if (in_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%b required=0", in_ready[1]); end
            total++;
            if ({out_valid[2], od(2)} !== {1'b1, 32'h1234})
                begin bad++; $display("FAIL bp_stall_hold got=%b/%h required=1/00001234", out_valid[2], od(2)); end
            @(posedge clk); #1;
        end
        out_ready[2] = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b required=1", in_ready[1]); end
        exp_q[2].push_back(32'hBEEF);
        @(posedge clk); #1;
        idle();
        total++;
        if ({out_valid[2], od(2)} !== {1'b1, 32'hBEEF})
            begin bad++; $display("FAIL bp_new_flit got=%b/%h required=1/0000beef", out_valid[2], od(2)); end
        @(posedge clk); #1;
    endtask

    task automatic test_conflict();
        total++;
        if (conflict_err !== 1'b0) begin bad++; $display("FAIL conf_pre_err got=%b required=0", conflict_err); end
        set_sel(1, 2); set_sel(3, 2);
        sel_en[1] = 1'b1; sel_en[3] = 1'b1;
        set_in(2, 32'h00C0FFEE);
        @(negedge clk);
        total++;
        if (in_ready !== 5'b00100) begin bad++; $display("FAIL conf_in_ready got=%b required=%b", in_ready, 5'b00100); end
        exp_q[1].push_back(32'h00C0FFEE);
        @(posedge clk); #1;
        idle();
        total++;
        if (out_valid !== 5'b00010) begin bad++; $display("FAIL conf_valid got=%b required=%b", out_valid, 5'b00010); end
        total++;
        if (conflict_err !== 1'b1) begin bad++; $display("FAIL conf_err got=%b required=1", conflict_err); end
        @(negedge clk);
        total++;
        if (in_ready !== 5'b0) begin bad++; $display("FAIL conf_ready_pulse got=%b required=0", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (conflict_err !== 1'b1) begin bad++; $display("FAIL conf_sticky got=%b required=1", conflict_err); end
    endtask

    task automatic test_out_of_range();
        apply_reset();
        total++;
        if (conflict_err !== 1'b0) begin bad++; $display("FAIL oor_reset_err got=%b required=0", conflict_err); end
        for (int k = 0; k < N_OUT; k++) set_sel(k, 6);
        for (int i = 0; i < N_IN; i++) set_in(i, 32'hD0 + 32'(i));
        sel_en = '0;
        @(posedge clk); #1;
        total++;
        if ({conflict_err, out_valid} !== 6'b0)
            begin bad++; $display("FAIL oor_disabled got=%b/%b required=0/00000", conflict_err, out_valid); end
        sel_en[0] = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 5'b0) begin bad++; $display("FAIL oor_in_ready got=%b required=0", in_ready); end
        @(posedge clk); #1;
        idle();
        total++;
        if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL oor_valid got=%b required=0", out_valid[0]); end
        total++;
        if (conflict_err !== 1'b1) begin bad++; $display("FAIL oor_err got=%b required=1", conflict_err); end
    endtask

    task automatic test_reset_mid_stream();
        apply_reset();
        out_ready = '1;
        set_sel(0, 0);
        sel_en[0] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            set_in(0, 32'h5000 + 32'(n));
            @(negedge clk);
            total++;
            if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL stream_ready n=%0d got=%b required=1", n, in_ready[0]); end
            exp_q[0].push_back(32'h5000 + 32'(n));
            @(posedge clk); #1;
        end
        idle();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 5'b0) begin bad++; $display("FAIL async_rst_valid got=%b required=0", out_valid); end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL async_rst_data got=%h required=0", out_data); end
        for (int k = 0; k < N_OUT; k++) exp_q[k].delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_sel(0, 0);
        sel_en[0] = 1'b1;
        set_in(0, 32'h6000);
        @(negedge clk);
        exp_q[0].push_back(32'h6000);
        @(posedge clk); #1;
        idle();
        total++;
        if ({out_valid, od(0)} !== {5'b00001, 32'h6000})
            begin bad++; $display("FAIL resume_latency got=%b/%h required=00001/00006000", out_valid, od(0)); end
        @(posedge clk); #1;
    endtask

`ifdef NOC_XBAR_STATS_EN
    task automatic test_stats();
        int exp_cnt;
        apply_reset();
        out_ready = '1;
        set_sel(0, 3);
        sel_en[0] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            set_in(3, 32'h7000 + 32'(n));
            @(negedge clk);
            exp_q[0].push_back(32'h7000 + 32'(n));
            @(posedge clk); #1;
            exp_cnt = (n + 1 > 15) ? 15 : n + 1;
            total++;
            if (flit_cnt[0 +: CNT_W] !== CNT_W'(exp_cnt))
                begin bad++; $display("FAIL stats_cnt n=%0d got=%h required=%h", n, flit_cnt[0 +: CNT_W], CNT_W'(exp_cnt)); end
        end
        idle();
        total++;
        if (flit_cnt[CNT_W*N_OUT-1:CNT_W] !== '0)
            begin bad++; $display("FAIL stats_others got=%h required=0", flit_cnt[CNT_W*N_OUT-1:CNT_W]); end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_drain();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N_OUT; k++) begin
            total++;
            if (exp_q[k].size() != 0)
                begin bad++; $display("FAIL drain out%0d got=%0d pending required=0", k, exp_q[k].size()); end
        end
    endtask

    initial begin
        in_data   = '0;
        sel       = '0;
        out_ready = '1;
        idle();
        test_reset();
        test_permutation();
        test_backpressure();
        test_conflict();
        test_out_of_range();
        test_reset_mid_stream();
`ifdef NOC_XBAR_STATS_EN
        test_stats();
`endif
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/noc_xbar_reg.md
Name: noc_xbar_reg

Overview:
- Parametrised N_IN x N_OUT router crossbar with per-output source select and valid/ready handshakes.
- Each output port has a registered stage (one flit deep) that supports backpressure; latency is one cycle.
- Sits between the input-buffer/VC stage and the output links; the switch allocator drives `sel`/`sel_en` each cycle.
- Replaces the 5x5, 32-bit, combinational, single-select crossbar.

Parameters:
- WIDTH, 32, flit width in bits.
- N_IN, 5, number of input ports (>=2).
- N_OUT, 5, number of output ports (>=2).
- SEL_W, $clog2(N_IN), width of each per-output select field.
- CNT_W, 16, statistics counter width (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH*N_IN  input flits; port i occupies [i*WIDTH +: WIDTH].
- in_valid  input  N_IN  flit present on input i.
- in_ready  output  N_IN  input i's flit is consumed this cycle.
- sel  input  SEL_W*N_OUT  source index for output k at [k*SEL_W +: SEL_W].
- sel_en  input  N_OUT  output k requests a transfer this cycle.
- out_data  output  WIDTH*N_OUT  registered output flits.
- out_valid  output  N_OUT  output register k holds a flit.
- out_ready  input  N_OUT  downstream accepts output k.
- conflict_err  output  1  sticky error: select conflict or out-of-range select.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0, conflict_err=0, counters=0. Any flit in flight is discarded.
- Stage k can load when `!out_valid[k] || out_ready[k]` (full throughput; pop and push in the same cycle are allowed).
- Candidate(k) = sel_en[k] && sel[k] < N_IN && in_valid[sel[k]].
- Conflict rule: if several candidate outputs select the same input, only the lowest-index output wins.
- Transfer(k) = candidate(k) && winner(k) && canload(k).
  - On the edge: out_data[k] <= in_data[sel[k]]; out_valid[k] <= 1.
- in_ready[i] = OR over k of (transfer(k) && sel[k]==i). This is combinational and may depend on out_ready.
- If a stage pops (out_valid && out_ready) with no transfer: out_valid[k] <= 0 and out_data holds its last value.
- If out_valid[k] && !out_ready[k]: out_data[k] and out_valid[k] stay stable. Inputs selecting k see in_ready=0.
- Latency: exactly 1 cycle from in_valid&&in_ready to out_valid.
- conflict_err is set on the edge after any cycle in which either:
  - two or more sel_en outputs hold the same in-range sel value, regardless of in_valid; or
  - sel_en[k]=1 with sel[k] >= N_IN.
- conflict_err is cleared only by reset.
- A losing or out-of-range output performs no transfer; its register behaves as if sel_en[k]=0.
- sel_en[k]=0: sel[k] is ignored and no error is raised for that output.
- No combinational path exists from in_data to out_data.

Optional Feature:
- Macro: NOC_XBAR_STATS_EN.
- With the macro defined, add output port `flit_cnt` (CNT_W*N_OUT).
  - Counter k increments by 1 on each transfer(k).
  - The counter saturates at all-ones and does not wrap.
  - Reset sets it to 0.
- Without the macro, the port and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Package noc_xbar_pkg holds:
  - default constants NOC_FLIT_W=32 and NOC_PORTS=5;
  - the port-index enum (LOCAL, NORTH, EAST, SOUTH, WEST = 0..4);
  - a select-width function equivalent to clog2.
- Sub-module noc_xbar_out_stage implements one output: mux result in, load/pop logic, data/valid register and optional counter.
- The top level instantiates N_OUT stages via generate and adds the winner/in_ready/error logic.

Test Plan (WIDTH=32, N_IN=N_OUT=5):
- Permutation, all out_ready=1:
  - Stimulus: sel={4,3,2,1,0} for outputs 0..4, all sel_en and in_valid set, in_data[i]=32'hA0+i.
  - Required: the next cycle out_data[k]=32'hA0+(4-k), all out_valid=1, all in_ready=1, conflict_err=0.
- Backpressure:
  - Stimulus: output 2 holds a flit with out_ready[2]=0 for 3 cycles while input 1 (0xBEEF) is selected.
  - Required: in_ready[1]=0 and out_data[2] stays stable. On the cycle out_ready[2]=1, in_ready[1]=1 and 0xBEEF appears the next cycle.
- Conflict:
  - Stimulus: outputs 1 and 3 both sel=2 with sel_en set.
  - Required: only out_valid[1] rises, in_ready[2] pulses once, and conflict_err=1 next cycle and stays 1.
- Out of range:
  - Stimulus: sel[0]=6 with sel_en[0]=1.
  - Required: no transfer, out_valid[0] stays 0, conflict_err=1.
- Reset mid-stream:
  - Stimulus: rst_n drops asynchronously while streaming back-to-back flits.
  - Required: out_valid=0 and out_data=0 immediately, without waiting for a clock edge. Streaming resumes with 1-cycle latency after release.
- With NOC_XBAR_STATS_EN and CNT_W=4:
  - Stimulus: 20 back-to-back transfers on output 0.
  - Required: flit_cnt[0] saturates at 4'hF.
